multicycle_alu: RTL
===================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (legal range 4..64).
REQ-002 SHALL have parameter SEL_W, default 4, opcode width (fixed at 4; other values illegal).
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 SHALL have ports A and B, input, WIDTH each, operands.
REQ-008 SHALL have port sel, input, 4, opcode.
REQ-009 SHALL have port Cin, input, 1, carry-in for ADD/SUB.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-012 SHALL have port Y, output, WIDTH, registered result.
REQ-013 SHALL have ports Cout, Negative, Zero, Overflow, Illegal, output, 1 each, registered flags.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 SHALL capture A, B, sel, Cin on in_valid&&in_ready; later input changes SHALL NOT affect the result.
REQ-016 SHALL decode sel: 0000 AND, 0001 OR, 0010 NOT A, 0011 NOR, 0100 XOR, 0101 NAND, 0110 ADD (A+B+Cin), 0111 SUB (A+~B+Cin), 1000 MUL, others illegal.
REQ-017 SHALL move IDLE->DONE one cycle after accept for all non-MUL opcodes (latency 1).
REQ-018 SHALL move IDLE->EXEC on MUL accept, iterate shift-add one bit per cycle for WIDTH cycles, then EXEC->DONE (latency WIDTH+1).
REQ-019 SHALL hold Y and all flags stable in DONE until out_ready is high, then go DONE->IDLE; out_ready outside DONE SHALL be ignored.
REQ-020 SHALL set Cout = carry out of bit WIDTH-1 for ADD/SUB, 0 otherwise.
REQ-021 SHALL set Overflow = signed two's-complement overflow for ADD/SUB, nonzero upper WIDTH bits of the 2*WIDTH unsigned product for MUL, 0 for logic ops.
REQ-022 SHALL set Negative = Y[WIDTH-1] and Zero = (Y==0) for every completed op.
REQ-023 SHALL, for illegal opcodes, produce Y=0, Illegal=1, Zero=1, other flags 0, latency 1; Illegal=0 for legal opcodes.
REQ-024 SHALL NOT accept a new request while in EXEC or DONE (no overlap, no queueing).

Reset
REQ-025 SHALL on rst_n low force state IDLE, Y=0, Cout=Negative=Overflow=Illegal=0, Zero=1, out_valid=0, in_ready=1 asynchronously.
REQ-026 SHALL abort any in-progress MUL on reset; no result SHALL be emitted for the aborted request.
REQ-027 SHALL release reset with in_ready high on the first clock edge after rst_n rises.

Configuration
REQ-028 SHALL compile MUL support only when macro MULTICYCLE_ALU_MUL_EN is defined.
REQ-029 SHALL, without MULTICYCLE_ALU_MUL_EN, omit EXEC state and multiplier logic and treat sel=1000 as illegal per REQ-023.

Structure
REQ-030 SHALL place opcode encodings and the FSM state enum in shared package alu_pkg.
REQ-031 SHALL implement the iterative multiplier as sub-module alu_mul_seq (start, done, WIDTH-parameterised, 2*WIDTH product), instantiated only under MULTICYCLE_ALU_MUL_EN.

Verification (WIDTH=32)
REQ-032 SHALL check ADD A=7FFFFFFF, B=1, Cin=0 -> after 1 cycle Y=80000000, Overflow=1, Negative=1, Cout=0, Zero=0.
REQ-033 SHALL check SUB A=5, B=5, Cin=1 -> Y=0, Zero=1, Cout=1, Overflow=0; and NAND A=FFFF0000, B=0F0F0F0F -> Y=F0F0FFFF.
REQ-034 SHALL check MUL A=00010000, B=00010000 with macro -> out_valid after 33 cycles, Y=0, Overflow=1, Zero=1; without macro -> Illegal=1 after 1 cycle.
REQ-035 SHALL check backpressure: out_ready low 5 cycles in DONE -> Y/flags stable, in_ready low, in_valid ignored; out_ready high -> IDLE next cycle.
REQ-036 SHALL check rst_n pulse mid-MUL (cycle 10 of 32) -> immediate IDLE, out_valid never asserted for that request, next ADD 2+3 gives Y=5.
REQ-037 SHALL check sel=1111 -> Y=0, Illegal=1, Zero=1, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state enum and flag payload for multicycle_alu.
// Optional feature macro: MULTICYCLE_ALU_MUL_EN adds the EXEC state used by
// the iterative multiplier.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_NOTA = 4'b0010,
    OP_NOR  = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_NAND = 4'b0101,
    OP_ADD  = 4'b0110,
    OP_SUB  = 4'b0111,
    OP_MUL  = 4'b1000
  } alu_op_e;

`ifdef MULTICYCLE_ALU_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DONE = 2'd1,
    ST_EXEC = 2'd2
  } alu_state_e;
`else
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DONE = 1'b1
  } alu_state_e;
`endif

  typedef struct packed {
    logic cout;
    logic negative;
    logic zero;
    logic overflow;
    logic illegal;
  } alu_flags_t;

  localparam alu_flags_t FLAGS_RST = '{cout: 1'b0, negative: 1'b0, zero: 1'b1,
                                       overflow: 1'b0, illegal: 1'b0};

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// Ports: clk, rst_n (async active-low), start (captures a/b), a, b,
//        done (one-cycle pulse when product is final), product (2*WIDTH).
module alu_mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  // Start loads operands; each busy cycle consumes the LSB of the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand_q  <= PW'(a);
        mplier_q <= b;
        cnt_q    <= '0;
        busy_q   <= 1'b1;
        product  <= '0;
      end else if (busy_q) begin
        if (mplier_q[0]) product <= product + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Handshaked ALU: single-cycle logic/add/sub, optional iterative multiply.
// Ports: clk, rst_n (async active-low); request side in_valid/in_ready with
//        operands A, B, opcode sel, carry-in Cin; result side out_valid/
//        out_ready with registered Y and flags Cout, Negative, Zero,
//        Overflow, Illegal. Result and flags hold while out_valid is high.
// Optional feature macro: MULTICYCLE_ALU_MUL_EN enables sel=1000 (MUL);
// without it that opcode reports Illegal.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SEL_W-1:0] sel,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             Cout,
  output logic             Negative,
  output logic             Zero,
  output logic             Overflow,
  output logic             Illegal
);

  localparam int unsigned SUM_W = WIDTH + 1;

  alu_state_e       state_q, state_d;
  alu_flags_t       flags_q, flags_c;
  logic [WIDTH-1:0] y_c, b_eff_c;
  logic [SUM_W-1:0] sum_c;
  logic             is_mul_c;
  logic             accept_c;

  assign accept_c = (state_q == ST_IDLE) && in_valid;

  // Single-cycle datapath evaluated on the live inputs; registered on accept.
  always_comb begin : alu_comb
    b_eff_c  = B;
    sum_c    = '0;
    y_c      = '0;
    flags_c  = '0;
    is_mul_c = 1'b0;
    case (sel)
      OP_AND:  y_c = A & B;
      OP_OR:   y_c = A | B;
      OP_NOTA: y_c = ~A;
      OP_NOR:  y_c = ~(A | B);
      OP_XOR:  y_c = A ^ B;
      OP_NAND: y_c = ~(A & B);
      OP_ADD, OP_SUB: begin
        if (sel == OP_SUB) b_eff_c = ~B;
        sum_c            = {1'b0, A} + {1'b0, b_eff_c} + SUM_W'(Cin);
        y_c              = sum_c[WIDTH-1:0];
        flags_c.cout     = sum_c[WIDTH];
        flags_c.overflow = (A[WIDTH-1] == b_eff_c[WIDTH-1]) &&
                           (y_c[WIDTH-1] != A[WIDTH-1]);
      end
`ifdef MULTICYCLE_ALU_MUL_EN
      OP_MUL:  is_mul_c = 1'b1;
`endif
      default: flags_c.illegal = 1'b1;
    endcase
    flags_c.negative = y_c[WIDTH-1];
    flags_c.zero     = (y_c == '0);
  end

`ifdef MULTICYCLE_ALU_MUL_EN
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  alu_flags_t         mul_flags_c;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept_c && is_mul_c),
    .a       (A),
    .b       (B),
    .done    (mul_done),
    .product (mul_product)
  );

  // Overflow flags any bit of the product that does not fit in WIDTH.
  always_comb begin : mul_flags
    mul_flags_c          = '0;
    mul_flags_c.overflow = |mul_product[2*WIDTH-1:WIDTH];
    mul_flags_c.negative = mul_product[WIDTH-1];
    mul_flags_c.zero     = (mul_product[WIDTH-1:0] == '0);
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = is_mul_c ? alu_state_e'(ST_DONE + 1'b0) : ST_DONE;
`ifdef MULTICYCLE_ALU_MUL_EN
      ST_EXEC: if (mul_done) state_d = ST_DONE;
`endif
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef MULTICYCLE_ALU_MUL_EN
    if (accept_c && is_mul_c) state_d = ST_EXEC;
`endif
  end

  // Handshake and result registers; result only changes when entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Y         <= '0;
      flags_q   <= FLAGS_RST;
    end else begin
      in_ready  <= (state_d == ST_IDLE);
      out_valid <= (state_d == ST_DONE);
      if (accept_c && !is_mul_c) begin
        Y       <= y_c;
        flags_q <= flags_c;
      end
`ifdef MULTICYCLE_ALU_MUL_EN
      else if ((state_q == ST_EXEC) && mul_done) begin
        Y       <= mul_product[WIDTH-1:0];
        flags_q <= mul_flags_c;
      end
`endif
    end
  end

  assign Cout     = flags_q.cout;
  assign Negative = flags_q.negative;
  assign Zero     = flags_q.zero;
  assign Overflow = flags_q.overflow;
  assign Illegal  = flags_q.illegal;

endmodule
